cve2_obi_arbiter: RTL and testbench
===================================

CVE2_OBI_ARBITER -- requirements
Module: cve2_obi_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, legal 1..4: maximum number of granted-but-unanswered transactions on the shared port.
REQ-002 SHALL have clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have instr_req_i/instr_gnt_o/instr_rvalid_o  in/out/out  1 each  instruction-port OBI handshake.
REQ-005 SHALL have instr_addr_i  input  32 and instr_rdata_o  output  32, instr_err_o  output  1: instruction address and response.
REQ-006 SHALL have data_req_i/data_gnt_o/data_rvalid_o  in/out/out  1 each  data-port OBI handshake.
REQ-007 SHALL have data_we_i  input  1, data_be_i  input  4, data_addr_i  input  32, data_wdata_i  input  32: data request payload.
REQ-008 SHALL have data_rdata_o  output  32 and data_err_o  output  1: data response.
REQ-009 SHALL have mem_req_o  output  1, mem_gnt_i  input  1, mem_rvalid_i  input  1: shared-port handshake.
REQ-010 SHALL have mem_we_o  output  1, mem_be_o  output  4, mem_addr_o  output  32, mem_wdata_o  output  32: shared request payload.
REQ-011 SHALL have mem_rdata_i  input  32, mem_err_i  input  1: shared response.
REQ-012 SHALL have busy_o  output  1: high while outstanding count is nonzero or mem_req_o is high.

Function
REQ-013 Grant accepted on the shared port SHALL be a cycle with mem_req_o & mem_gnt_i; mem_gnt_i when mem_req_o is low SHALL be ignored.
REQ-014 Selection: only one requester -> that one; both -> the one not granted most recently (round-robin, last-winner flag); flag reset value selects data on first contention.
REQ-015 Once mem_req_o is asserted for a selected master, selection SHALL be locked (registered) until that request is granted, regardless of other requests; payload and mem_req_o SHALL stay stable.
REQ-016 Lock SHALL also hold if the selected master drops req before grant (OBI violation); mem_req_o then follows that master's req and lock releases when it deasserts.
REQ-017 mem_gnt_i SHALL be forwarded combinationally only to the selected master's gnt; the other gnt SHALL be 0.
REQ-018 When instruction is selected: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0, mem_addr_o=instr_addr_i; data selected: data payload passed through.
REQ-019 Owner FIFO (depth MaxOutstanding, 1 bit per entry: 0=instr, 1=data) SHALL push the granted owner on each accepted grant.
REQ-020 When FIFO is full, mem_req_o SHALL be 0 and both gnt outputs 0; full blocks even if a pop occurs the same cycle.
REQ-021 mem_rvalid_i SHALL be routed combinationally to the FIFO head owner's rvalid, with mem_rdata_i and mem_err_i; the other rvalid SHALL be 0; FIFO pops.
REQ-022 rdata/err outputs SHALL carry mem_rdata_i/mem_err_i unconditionally; only rvalid is steered.
REQ-023 Simultaneous grant and rvalid SHALL push and pop in the same cycle; count unchanged; pointers wrap modulo MaxOutstanding.
REQ-024 mem_rvalid_i with FIFO empty SHALL be dropped (no rvalid out) and flagged by assertion.
REQ-025 Response order SHALL equal grant order; zero-cycle added latency on request and response paths.
REQ-026 Minimum latency: request in cycle N may be granted in cycle N when unlocked and not full.

Reset
REQ-027 On rst_ni low: FIFO empty, pointers 0, lock cleared, last-winner = instruction; mem_req_o=0, all gnt/rvalid outputs 0, busy_o=0, immediately and asynchronously.
REQ-028 Reset mid-transaction SHALL discard outstanding owners; responses arriving after reset are dropped per REQ-024.

Verification
REQ-029 Both req high from reset, mem_gnt_i=1 always, rvalid one cycle later -> grants alternate data, instr, data, instr; each rvalid on matching port.
REQ-030 Instr req, mem_gnt_i=0 for 3 cycles, data req rises in cycle 1 -> mem_addr_o stays instr_addr_i until grant; data granted next.
REQ-031 MaxOutstanding=2, 3 data requests, no rvalid -> two grants, third held, mem_req_o=0; one rvalid -> third granted next cycle.
REQ-032 Grant and rvalid same cycle with count=1 -> count stays 1, busy_o stays 1, correct owner receives rvalid.
REQ-033 Instr write-free path: instr selected -> mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0 checked.
REQ-034 rst_ni pulsed low with 2 outstanding -> all outputs 0, busy_o=0; subsequent stray rvalid produces no port rvalid.

Source files
------------

// File: rtl/cve2_obi_arbiter.sv
// Two-master OBI arbiter: instruction and data ports share a single memory port.
// Round-robin on contention, with a lock held until grant and in-order response steering.
module cve2_obi_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,

    output logic        busy_o
);

    // Handshake: a request is accepted in any cycle with req & gnt; a response is one
    // rvalid pulse, returned in the same order the requests were accepted.

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic                      lock_q;
    logic                      lock_data_q;
    logic                      last_data_q;
    logic [MaxOutstanding-1:0] owner_q;
    logic [PtrW-1:0]           wptr_q;
    logic [PtrW-1:0]           rptr_q;
    logic [CntW-1:0]           count_q;

    logic sel_data;
    logic sel_req;
    logic full;
    logic push;
    logic pop;
    logic head_data;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(MaxOutstanding - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    always_comb begin
        sel_data = data_req_i;
        if (lock_q) begin
            sel_data = lock_data_q;
        end else if (instr_req_i && data_req_i) begin
            sel_data = ~last_data_q;
        end
    end

    assign sel_req   = sel_data ? data_req_i : instr_req_i;
    assign full      = (count_q == CntW'(MaxOutstanding));
    // Gated by reset so the request drops immediately, not at the next edge.
    assign mem_req_o = rst_ni & sel_req & ~full;
    assign push      = mem_req_o & mem_gnt_i;
    assign pop       = mem_rvalid_i & (count_q != '0);
    assign head_data = owner_q[rptr_q];

    assign instr_gnt_o = mem_req_o & mem_gnt_i & ~sel_data;
    assign data_gnt_o  = mem_req_o & mem_gnt_i & sel_data;

    assign mem_we_o    = sel_data ? data_we_i    : 1'b0;
    assign mem_be_o    = sel_data ? data_be_i    : 4'hF;
    assign mem_addr_o  = sel_data ? data_addr_i  : instr_addr_i;
    assign mem_wdata_o = sel_data ? data_wdata_i : 32'h0;

    assign instr_rvalid_o = pop & ~head_data;
    assign data_rvalid_o  = pop & head_data;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;

    assign busy_o = (count_q != '0) | mem_req_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q      <= 1'b0;
            lock_data_q <= 1'b0;
            last_data_q <= 1'b0;
            owner_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            // Lock whenever a request is shown but not taken; dropping req also releases it.
            lock_q <= mem_req_o & ~mem_gnt_i;
            if (mem_req_o && !mem_gnt_i) begin
                lock_data_q <= sel_data;
            end
            if (push) begin
                owner_q[wptr_q] <= sel_data;
                wptr_q          <= ptr_inc(wptr_q);
                last_data_q     <= sel_data;
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifndef SYNTHESIS
    stray_rvalid_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mem_rvalid_i && count_q == '0))
        else $warning("rvalid with no outstanding transaction, response dropped");
`endif

endmodule

// File: tb/tb_cve2_obi_arbiter.sv
// Directed bench for cve2_obi_arbiter: a per-cycle vector table plus hand-written
// sequences for reset with transactions outstanding.
module tb_cve2_obi_arbiter;

    localparam logic [31:0] INSTR_ADDR = 32'h0000_1000;
    localparam logic [31:0] DATA_ADDR  = 32'h0000_2000;
    localparam logic [31:0] DATA_WDATA = 32'hDEAD_BEEF;
    localparam logic [3:0]  DATA_BE    = 4'h5;
    localparam int          NV         = 20;

    logic        clk;
    logic        rst_n;
    logic        instr_req, instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_gnt, data_rvalid, data_we, data_err;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_gnt, mem_rvalid, mem_we, mem_err;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    cve2_obi_arbiter #(.MaxOutstanding(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .instr_req_i   (instr_req),
        .instr_gnt_o   (instr_gnt),
        .instr_rvalid_o(instr_rvalid),
        .instr_addr_i  (instr_addr),
        .instr_rdata_o (instr_rdata),
        .instr_err_o   (instr_err),
        .data_req_i    (data_req),
        .data_gnt_o    (data_gnt),
        .data_rvalid_o (data_rvalid),
        .data_we_i     (data_we),
        .data_be_i     (data_be),
        .data_addr_i   (data_addr),
        .data_wdata_i  (data_wdata),
        .data_rdata_o  (data_rdata),
        .data_err_o    (data_err),
        .mem_req_o     (mem_req),
        .mem_gnt_i     (mem_gnt),
        .mem_rvalid_i  (mem_rvalid),
        .mem_we_o      (mem_we),
        .mem_be_o      (mem_be),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .mem_err_i     (mem_err),
        .busy_o        (busy)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ireq, dreq, gnt, rv;
        logic        mreq, ignt, dgnt, irv, drv, busy;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic ireq, dreq, gnt, rv,
                                input logic mreq, ignt, dgnt, irv, drv, bsy,
                                input logic [31:0] addr);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.gnt = gnt; v.rv = rv;
        v.mreq = mreq; v.ignt = ignt; v.dgnt = dgnt;
        v.irv = irv; v.drv = drv; v.busy = bsy; v.addr = addr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ireq, dreq, gnt, rv, input logic [31:0] rdata, input logic err);
        instr_req  = ireq;
        data_req   = dreq;
        mem_gnt    = gnt;
        mem_rvalid = rv;
        mem_rdata  = rdata;
        mem_err    = err;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_req"},      32'(mem_req),      32'h0);
        check({tag, " instr_gnt"},    32'(instr_gnt),    32'h0);
        check({tag, " data_gnt"},     32'(data_gnt),     32'h0);
        check({tag, " instr_rvalid"}, 32'(instr_rvalid), 32'h0);
        check({tag, " data_rvalid"},  32'(data_rvalid),  32'h0);
        check({tag, " busy"},         32'(busy),         32'h0);
    endtask

    // scoreboard: expected per-cycle outputs, listed in cycle order
    initial begin
        //              ireq dreq gnt rv  | mreq ignt dgnt irv drv busy addr
        // both requesting, always granted, rvalid one cycle later: data first, then alternating
        vecs[0]  = mk(1, 1, 1, 0,   1, 0, 1, 0, 0, 1, DATA_ADDR);
        vecs[1]  = mk(1, 1, 1, 1,   1, 1, 0, 0, 1, 1, INSTR_ADDR);
        vecs[2]  = mk(1, 1, 1, 1,   1, 0, 1, 1, 0, 1, DATA_ADDR);
        vecs[3]  = mk(1, 1, 1, 1,   1, 1, 0, 0, 1, 1, INSTR_ADDR);
        vecs[4]  = mk(0, 0, 0, 1,   0, 0, 0, 1, 0, 1, INSTR_ADDR);
        vecs[5]  = mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, INSTR_ADDR);
        // instr held 3 cycles without grant while data arrives: stays locked on instr
        vecs[6]  = mk(1, 0, 0, 0,   1, 0, 0, 0, 0, 1, INSTR_ADDR);
        vecs[7]  = mk(1, 1, 0, 0,   1, 0, 0, 0, 0, 1, INSTR_ADDR);
        vecs[8]  = mk(1, 1, 0, 0,   1, 0, 0, 0, 0, 1, INSTR_ADDR);
        vecs[9]  = mk(1, 1, 1, 0,   1, 1, 0, 0, 0, 1, INSTR_ADDR);
        vecs[10] = mk(0, 1, 1, 0,   1, 0, 1, 0, 0, 1, DATA_ADDR);
        // two outstanding: full blocks, even alongside a pop
        vecs[11] = mk(0, 1, 1, 0,   0, 0, 0, 0, 0, 1, DATA_ADDR);
        vecs[12] = mk(0, 1, 1, 1,   0, 0, 0, 1, 0, 1, DATA_ADDR);
        // grant and rvalid together at count 1
        vecs[13] = mk(0, 1, 1, 1,   1, 0, 1, 0, 1, 1, DATA_ADDR);
        vecs[14] = mk(0, 0, 0, 1,   0, 0, 0, 0, 1, 1, INSTR_ADDR);
        vecs[15] = mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, INSTR_ADDR);
        // data drops req before grant: lock follows data, then releases
        vecs[16] = mk(0, 1, 0, 0,   1, 0, 0, 0, 0, 1, DATA_ADDR);
        vecs[17] = mk(1, 0, 0, 0,   0, 0, 0, 0, 0, 0, DATA_ADDR);
        vecs[18] = mk(1, 0, 1, 0,   1, 1, 0, 0, 0, 1, INSTR_ADDR);
        vecs[19] = mk(0, 0, 0, 1,   0, 0, 0, 1, 0, 1, INSTR_ADDR);
    end

    initial begin
        instr_addr = INSTR_ADDR;
        data_addr  = DATA_ADDR;
        data_we    = 1'b1;
        data_be    = DATA_BE;
        data_wdata = DATA_WDATA;
        rst_n      = 1'b0;
        drive(1, 1, 1, 1, 32'h0, 1'b0);
        #1;
        check_all_zero("reset");

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            logic        is_data;
            logic [31:0] rd;
            @(negedge clk);
            rd = 32'hCAFE_0000 | 32'(i);
            drive(vecs[i].ireq, vecs[i].dreq, vecs[i].gnt, vecs[i].rv, rd, 1'(i & 1));
            #1;
            is_data = (vecs[i].addr == DATA_ADDR);
            check($sformatf("v%0d mem_req", i),      32'(mem_req),      32'(vecs[i].mreq));
            check($sformatf("v%0d instr_gnt", i),    32'(instr_gnt),    32'(vecs[i].ignt));
            check($sformatf("v%0d data_gnt", i),     32'(data_gnt),     32'(vecs[i].dgnt));
            check($sformatf("v%0d instr_rvalid", i), 32'(instr_rvalid), 32'(vecs[i].irv));
            check($sformatf("v%0d data_rvalid", i),  32'(data_rvalid),  32'(vecs[i].drv));
            check($sformatf("v%0d busy", i),         32'(busy),         32'(vecs[i].busy));
            check($sformatf("v%0d mem_addr", i),     mem_addr,          vecs[i].addr);
            check($sformatf("v%0d mem_we", i),       32'(mem_we),       is_data ? 32'h1 : 32'h0);
            check($sformatf("v%0d mem_be", i),       32'(mem_be),       is_data ? 32'(DATA_BE) : 32'hF);
            check($sformatf("v%0d mem_wdata", i),    mem_wdata,         is_data ? DATA_WDATA : 32'h0);
            check($sformatf("v%0d instr_rdata", i),  instr_rdata,       rd);
            check($sformatf("v%0d data_rdata", i),   data_rdata,        rd);
            check($sformatf("v%0d instr_err", i),    32'(instr_err),    32'(i & 1));
            check($sformatf("v%0d data_err", i),     32'(data_err),     32'(i & 1));
        end

        // two data grants outstanding, then asynchronous reset mid-cycle
        @(negedge clk);
        drive(0, 1, 1, 0, 32'h0, 1'b0);
        #1;
        check("rst_seq first grant", 32'(data_gnt), 32'h1);
        @(negedge clk);
        #1;
        check("rst_seq second grant", 32'(data_gnt), 32'h1);
        @(negedge clk);
        #1;
        check("rst_seq full mem_req", 32'(mem_req), 32'h0);
        check("rst_seq full busy", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        drive(1, 1, 1, 1, 32'h0, 1'b0);
        #1;
        check_all_zero("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 32'h1234_5678, 1'b0);
        #1;
        check_all_zero("stray rvalid");
        @(negedge clk);
        // contention right after reset goes to data again
        drive(1, 1, 1, 0, 32'h0, 1'b0);
        #1;
        check("post reset data_gnt", 32'(data_gnt), 32'h1);
        check("post reset instr_gnt", 32'(instr_gnt), 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 1, 32'h0, 1'b0);
        #1;
        check("post reset data_rvalid", 32'(data_rvalid), 32'h1);
        check("post reset instr_rvalid", 32'(instr_rvalid), 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h0, 1'b0);
        #1;
        check("post reset idle busy", 32'(busy), 32'h0);

        // report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
